sa_cache_ctrl: RTL and testbench
================================

Name: sa_cache_ctrl

Overview:
- Parametrised two-way set-associative read cache between the memory stage and the SRAM controller.
- Line size, set count and address width are configurable.
- Cache misses and writes are sequenced by an explicit FSM with held SRAM handshakes.
- Writes are write-through and no-allocate; write hits can update the cached line in place.
- Exposes hit and miss statistics counters.

Parameters:
ADDR_W, 19, number of significant byte-address bits; address[31:ADDR_W] ignored
SET_W, 6, log2 of set count (64 sets)
LINE_WORDS, 2, 32-bit words per line; legal values 1, 2, 4
UPDATE_ON_WRITE, 1, 1 = write hit updates cached word; 0 = write hit invalidates the line

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_en  in  1  read request, held until ready
wr_en  in  1  write request, held until ready
address  in  32  byte address
write_data  in  32  store data
read_data  out  32  load data, valid while ready=1 on a read
ready  out  1  request completes at this clock edge
sram_rd_en  out  1  line read request to SRAM controller
sram_wr_en  out  1  word write request to SRAM controller
sram_address  out  32  line-aligned for reads, word address for writes
sram_write_data  out  32  equals write_data
sram_read_data  in  32*LINE_WORDS  line from SRAM, word 0 in bits [31:0]
sram_ready  in  1  SRAM transfer done this cycle
hit_count  out  32  read hits since reset
miss_count  out  32  read misses since reset

Behaviour:
Address split:
- OFF_W = 2 + log2(LINE_WORDS).
- Word select = address[OFF_W-1:2].
- Index = address[OFF_W+SET_W-1:OFF_W].
- Tag = address[ADDR_W-1:OFF_W+SET_W].

Storage:
- Per set: 2 ways, each holding a line, tag and valid bit.
- One LRU bit per set, pointing at the way to replace next.

Reset:
- Clears all valid bits, LRU bits, hit_count, miss_count and the FSM (to IDLE).
- Line and tag arrays are not reset.
- All outputs read 0 during reset, including read_data.

Hit:
- A way hits when it is valid and its tag matches.
- Both ways hitting is impossible by construction.

FSM states: IDLE, RD_MISS, WRITE.
- IDLE, rd_en=1 and hit: ready=1 combinationally in the same cycle; read_data = hit word. At the edge, hit_count+1 and LRU = other way. Stay in IDLE.
- IDLE, rd_en=1 and miss: go to RD_MISS. ready=0 in this cycle.
- IDLE, wr_en=1: go to WRITE. wr_en has priority over rd_en when both are 1; the read is not serviced.
- RD_MISS: sram_rd_en=1 and sram_address = {address[31:OFF_W], OFF_W'b0}, held until sram_ready.
  - On the sram_ready cycle: ready=1 and read_data = requested word from sram_read_data (bypass).
  - At that edge: fill the victim way (line, tag, valid=1); LRU = other way; miss_count+1; go to IDLE.
  - Victim way: way0 if invalid, else way1 if invalid, else the way indicated by LRU.
- WRITE: sram_wr_en=1 and sram_address = {address[31:2], 2'b00}, held until sram_ready.
  - On the sram_ready cycle: ready=1.
  - At that edge, on a write hit: if UPDATE_ON_WRITE=1, replace the selected word of the hit way and set LRU = other way; otherwise clear the hit way's valid bit and set LRU = that way.
  - Write miss: no allocation.
  - Go to IDLE.
- Latency: read hit = 0 cycles; read miss = 1 + SRAM latency; write = 1 + SRAM latency.
- sram_rd_en and sram_wr_en are never both 1.
- The requester must hold address and data stable until ready. A request that drops early leaves the FSM in its state until sram_ready.
- Counters wrap from 0xFFFFFFFF to 0. Writes do not count.
- Reset mid-RD_MISS or mid-WRITE:
  - Immediate return to IDLE; SRAM enables drop asynchronously.
  - No fill or update occurs, and counters stay at 0.
- Tag and hit are re-evaluated at the sram_ready edge using the held address.

Test Plan:
- Reset, read 0x104 (defaults) -> sram_rd_en=1 with sram_address=0x100. After 3 cycles, sram_ready with sram_read_data=0xBBBBBBBB_AAAAAAAA -> ready=1, read_data=0xBBBBBBBB, miss_count=1. Then read 0x100 -> same-cycle ready, read_data=0xAAAAAAAA, hit_count=1, sram_rd_en stays 0.
- LRU replacement in set 32: fill 0x100, fill 0x300, read 0x100 (hit), read 0x500 (miss) -> 0x300 evicted. Subsequent 0x100 hits; subsequent 0x300 misses.
- UPDATE_ON_WRITE=1, line 0x100 cached: write 0x104 data 0x12345678, sram_ready after 2 cycles -> ready pulses once. Then read 0x104 hits with 0x12345678. Repeat with UPDATE_ON_WRITE=0 -> the read misses.
- Write miss 0x700 -> sram_wr_en=1 with sram_address=0x700 until sram_ready. Then read 0x700 misses (no allocate).
- rd_en=wr_en=1 at 0x100 -> only sram_wr_en asserts; hit_count and miss_count unchanged.
- Assert rst during RD_MISS before sram_ready -> sram_rd_en=0 immediately. After release, read of the same address misses again with miss_count=1.
- LINE_WORDS=4: fill 0x10C with a 128-bit line -> read_data = bits [127:96]; read 0x104 hits with bits [63:32].

Source files
------------

// File: rtl/sa_cache_ctrl.sv
// Two-way set-associative read cache with write-through, no-allocate stores.
// Misses and stores are sequenced through a held SRAM handshake.
module sa_cache_ctrl #(
  parameter int ADDR_W          = 19,
  parameter int SET_W           = 6,
  parameter int LINE_WORDS      = 2,
  parameter int UPDATE_ON_WRITE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       ready,
  output logic                       sram_rd_en,
  output logic                       sram_wr_en,
  output logic [31:0]                sram_address,
  output logic [31:0]                sram_write_data,
  input  logic [32*LINE_WORDS-1:0]   sram_read_data,
  input  logic                       sram_ready,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
);

  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF_W  = 2 + $clog2(LINE_WORDS);
  localparam int SETS   = 1 << SET_W;
  localparam int TAG_W  = ADDR_W - OFF_W - SET_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SETS-1:0]   vld0_q, vld0_d;
  logic [SETS-1:0]   vld1_q, vld1_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  logic [LINE_W-1:0] line_q [2][SETS];
  logic [TAG_W-1:0]  tag_q  [2][SETS];

  logic [WSEL_W-1:0] wsel;
  logic [SET_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic              hit0, hit1, hit, hit_way, victim;
  logic [LINE_W-1:0] hit_line, line_wd;
  logic [31:0]       hit_word, fill_word;
  logic              line_we, line_way;
  logic              ready_c, srd_c, swr_c;
  logic [31:0]       rdata_c, saddr_c;
  logic              unused_ok;

  assign unused_ok = ^address[1:0];
  assign wsel   = WSEL_W'((address >> 2) & (LINE_WORDS - 1));
  assign idx    = address[OFF_W+SET_W-1:OFF_W];
  assign tag_in = address[ADDR_W-1:OFF_W+SET_W];

  assign hit0     = vld0_q[idx] && (tag_q[0][idx] == tag_in);
  assign hit1     = vld1_q[idx] && (tag_q[1][idx] == tag_in);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = hit1 ? line_q[1][idx] : line_q[0][idx];
  assign hit_word = hit_line[{wsel, 5'b0} +: 32];
  assign fill_word = sram_read_data[{wsel, 5'b0} +: 32];

  // Invalid ways fill first so LRU only arbitrates a full set.
  assign victim = !vld0_q[idx] ? 1'b0 :
                  !vld1_q[idx] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d      = state_q;
    vld0_d       = vld0_q;
    vld1_d       = vld1_q;
    lru_d        = lru_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    line_way     = 1'b0;
    line_wd      = sram_read_data;
    ready_c      = 1'b0;
    srd_c        = 1'b0;
    swr_c        = 1'b0;
    rdata_c      = 32'd0;
    saddr_c      = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = WRITE;
        end else if (rd_en) begin
          if (hit) begin
            ready_c     = 1'b1;
            rdata_c     = hit_word;
            hit_count_d = hit_count_q + 32'd1;
            lru_d[idx]  = ~hit_way;
          end else begin
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        srd_c   = 1'b1;
        saddr_c = {address[31:OFF_W], {OFF_W{1'b0}}};
        if (sram_ready) begin
          ready_c      = 1'b1;
          rdata_c      = fill_word;
          line_we      = 1'b1;
          line_way     = victim;
          lru_d[idx]   = ~victim;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = IDLE;
          if (victim) vld1_d[idx] = 1'b1;
          else        vld0_d[idx] = 1'b1;
        end
      end
      WRITE: begin
        swr_c   = 1'b1;
        saddr_c = {address[31:2], 2'b00};
        if (sram_ready) begin
          ready_c = 1'b1;
          state_d = IDLE;
          if (hit && UPDATE_ON_WRITE != 0) begin
            line_we  = 1'b1;
            line_way = hit_way;
            line_wd  = hit_line;
            line_wd[{wsel, 5'b0} +: 32] = write_data;
            lru_d[idx] = ~hit_way;
          end else if (hit) begin
            lru_d[idx] = hit_way;
            if (hit_way) vld1_d[idx] = 1'b0;
            else         vld0_d[idx] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vld0_q       <= '0;
      vld1_q       <= '0;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      vld0_q       <= vld0_d;
      vld1_q       <= vld1_d;
      lru_q        <= lru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Data and tags are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q[line_way][idx] <= line_wd;
      tag_q[line_way][idx]  <= tag_in;
    end
  end

  assign ready           = ready_c & ~rst;
  assign read_data       = rst ? 32'd0 : rdata_c;
  assign sram_rd_en      = srd_c & ~rst;
  assign sram_wr_en      = swr_c & ~rst;
  assign sram_address    = rst ? 32'd0 : saddr_c;
  assign sram_write_data = rst ? 32'd0 : write_data;
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Bench for sa_cache_ctrl: three configurations against an LRU-list model.
// Directed scenarios first, then randomized reads/writes per configuration.
module tb_sa_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en, wr_en, sram_ready;
  logic [31:0]  address, write_data;
  logic [127:0] line_in;
  int           sel;

  logic         rdy [3];
  logic         srd [3];
  logic         swr [3];
  logic [31:0]  rdat [3];
  logic [31:0]  sadr [3];
  logic [31:0]  swd [3];
  logic [31:0]  hcnt [3];
  logic [31:0]  mcnt [3];

  int n_chk = 0;
  int n_err = 0;

  int lw   [3] = '{2, 2, 4};
  int uow  [3] = '{1, 0, 1};
  int offw [3] = '{3, 3, 4};

  longint unsigned  slot [3][64][2];
  int               cnt  [3][64];
  logic [127:0]     ldata [longint unsigned];
  logic [31:0]      m_hit [3];
  logic [31:0]      m_miss [3];

  always #5 clk = ~clk;

  sa_cache_ctrl u_dut0 (
    .clk(clk), .rst(rst),
    .rd_en(rd_en && sel == 0), .wr_en(wr_en && sel == 0),
    .address(address), .write_data(write_data),
    .read_data(rdat[0]), .ready(rdy[0]),
    .sram_rd_en(srd[0]), .sram_wr_en(swr[0]),
    .sram_address(sadr[0]), .sram_write_data(swd[0]),
    .sram_read_data(line_in[63:0]), .sram_ready(sram_ready && sel == 0),
    .hit_count(hcnt[0]), .miss_count(mcnt[0])
  );

  sa_cache_ctrl #(.UPDATE_ON_WRITE(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .rd_en(rd_en && sel == 1), .wr_en(wr_en && sel == 1),
    .address(address), .write_data(write_data),
    .read_data(rdat[1]), .ready(rdy[1]),
    .sram_rd_en(srd[1]), .sram_wr_en(swr[1]),
    .sram_address(sadr[1]), .sram_write_data(swd[1]),
    .sram_read_data(line_in[63:0]), .sram_ready(sram_ready && sel == 1),
    .hit_count(hcnt[1]), .miss_count(mcnt[1])
  );

  sa_cache_ctrl #(.LINE_WORDS(4)) u_dut2 (
    .clk(clk), .rst(rst),
    .rd_en(rd_en && sel == 2), .wr_en(wr_en && sel == 2),
    .address(address), .write_data(write_data),
    .read_data(rdat[2]), .ready(rdy[2]),
    .sram_rd_en(srd[2]), .sram_wr_en(swr[2]),
    .sram_address(sadr[2]), .sram_write_data(swd[2]),
    .sram_read_data(line_in), .sram_ready(sram_ready && sel == 2),
    .hit_count(hcnt[2]), .miss_count(mcnt[2])
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  function automatic longint unsigned line_key(int k, logic [31:0] a);
    return longint'((a & 32'h0007_FFFF) >> offw[k]);
  endfunction

  function automatic int wsel(int k, logic [31:0] a);
    return int'((a >> 2) & (lw[k] - 1));
  endfunction

  function automatic logic [31:0] word_of(logic [127:0] l, int w);
    logic [127:0] t;
    t = l >> (32 * w);
    return t[31:0];
  endfunction

  function automatic int find(int k, int s, longint unsigned key);
    for (int i = 0; i < cnt[k][s]; i++)
      if (slot[k][s][i] == key) return i;
    return -1;
  endfunction

  // slot[..][0] is least recently used, slot[..][1] most recently used.
  function automatic void touch(int k, int s, int i);
    longint unsigned t;
    if (cnt[k][s] == 2 && i == 0) begin
      t = slot[k][s][0];
      slot[k][s][0] = slot[k][s][1];
      slot[k][s][1] = t;
    end
  endfunction

  function automatic void insert(int k, int s, longint unsigned key);
    if (cnt[k][s] < 2) begin
      slot[k][s][cnt[k][s]] = key;
      cnt[k][s]++;
    end else begin
      slot[k][s][0] = slot[k][s][1];
      slot[k][s][1] = key;
    end
  endfunction

  function automatic void remove(int k, int s, int i);
    if (i == 0 && cnt[k][s] == 2) slot[k][s][0] = slot[k][s][1];
    cnt[k][s]--;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 64; s++) cnt[k][s] = 0;
      m_hit[k]  = 0;
      m_miss[k] = 0;
    end
    ldata.delete();
  endfunction

  task automatic check_counts(int k);
    chk("hit_count", hcnt[k], m_hit[k]);
    chk("miss_count", mcnt[k], m_miss[k]);
  endtask

  task automatic do_read(int k, logic [31:0] a, logic [127:0] fill, int lat);
    longint unsigned key, dk;
    int s, i;
    logic [31:0] line_a;
    key = line_key(k, a);
    dk  = key * 4 + longint'(k);
    s   = int'(key & 63);
    i   = find(k, s, key);
    line_a = a & ~((32'd1 << offw[k]) - 1);
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; address = a; sram_ready = 1'b0;
    #1;
    if (i >= 0) begin
      chk("rd_hit_ready", rdy[k], 1);
      chk("rd_hit_data", rdat[k], word_of(ldata[dk], wsel(k, a)));
      chk("rd_hit_srd", srd[k], 0);
      touch(k, s, i);
      m_hit[k]++;
    end else begin
      chk("rd_miss_ready0", rdy[k], 0);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk); #1;
        chk("rd_miss_srd", srd[k], 1);
        chk("rd_miss_swr", swr[k], 0);
        chk("rd_miss_addr", sadr[k], line_a);
        chk("rd_miss_wait", rdy[k], 0);
      end
      @(negedge clk);
      sram_ready = 1'b1; line_in = fill;
      #1;
      chk("rd_miss_ready", rdy[k], 1);
      chk("rd_miss_data", rdat[k], word_of(fill, wsel(k, a)));
      chk("rd_miss_addr_rdy", sadr[k], line_a);
      insert(k, s, key);
      ldata[dk] = fill;
      m_miss[k]++;
    end
    @(negedge clk);
    rd_en = 1'b0; sram_ready = 1'b0;
    #1;
    check_counts(k);
  endtask

  task automatic do_write(int k, logic [31:0] a, logic [31:0] d, int lat, bit both);
    longint unsigned key, dk;
    int s, i;
    logic [127:0] l;
    key = line_key(k, a);
    dk  = key * 4 + longint'(k);
    s   = int'(key & 63);
    i   = find(k, s, key);
    @(negedge clk);
    wr_en = 1'b1; rd_en = both; address = a; write_data = d; sram_ready = 1'b0;
    #1;
    chk("wr_req_ready", rdy[k], 0);
    chk("wr_req_srd", srd[k], 0);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk); #1;
      chk("wr_swr", swr[k], 1);
      chk("wr_srd", srd[k], 0);
      chk("wr_addr", sadr[k], a & 32'hFFFF_FFFC);
      chk("wr_wdata", swd[k], d);
      chk("wr_wait", rdy[k], 0);
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    chk("wr_ready", rdy[k], 1);
    chk("wr_swr_rdy", swr[k], 1);
    if (i >= 0) begin
      if (uow[k] != 0) begin
        l = ldata[dk];
        l[32 * wsel(k, a) +: 32] = d;
        ldata[dk] = l;
        touch(k, s, i);
      end else begin
        remove(k, s, i);
      end
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; sram_ready = 1'b0;
    #1;
    chk("wr_done_swr", swr[k], 0);
    check_counts(k);
  endtask

  function automatic logic [31:0] rand_addr(int k);
    logic [31:0] a;
    a = ($urandom_range(0, 3) << (offw[k] + 6))
      | ($urandom_range(0, 1) << offw[k])
      | ($urandom_range(0, 3) << 2)
      | $urandom_range(0, 3);
    if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFF8_0000);
    return a;
  endfunction

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
    address = 32'h0; write_data = 32'h0; line_in = '0; sel = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rd_en = 1'b1; address = 32'h104;
    #1;
    chk("rst_ready", rdy[0], 0);
    chk("rst_rdata", rdat[0], 0);
    chk("rst_srd", srd[0], 0);
    check_counts(0);
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;

    do_read(0, 32'h104, 128'hBBBBBBBB_AAAAAAAA, 3);
    do_read(0, 32'h100, 128'h0, 0);
    do_read(0, 32'h300, {$urandom, $urandom, $urandom, $urandom}, 1);
    do_read(0, 32'h100, 128'h0, 0);
    do_read(0, 32'h500, {$urandom, $urandom, $urandom, $urandom}, 2);
    do_read(0, 32'h100, 128'h0, 0);
    do_read(0, 32'h300, {$urandom, $urandom, $urandom, $urandom}, 1);
    do_write(0, 32'h104, 32'h12345678, 2, 1'b0);
    do_read(0, 32'h104, 128'h0, 0);
    do_write(0, 32'h700, 32'hCAFEF00D, 3, 1'b0);
    do_read(0, 32'h700, {$urandom, $urandom, $urandom, $urandom}, 1);
    do_write(0, 32'h100, 32'h55AA55AA, 1, 1'b1);

    sel = 1;
    do_read(1, 32'h100, 128'h22222222_11111111, 1);
    do_write(1, 32'h104, 32'h12345678, 2, 1'b0);
    do_read(1, 32'h104, 128'h44444444_33333333, 1);

    sel = 2;
    do_read(2, 32'h10C, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2);
    do_read(2, 32'h104, 128'h0, 0);

    sel = 0;
    @(negedge clk);
    rd_en = 1'b1; address = 32'h2_0000;
    @(negedge clk); #1;
    chk("mid_miss_srd", srd[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_drop_srd", srd[0], 0);
    chk("rst_drop_ready", rdy[0], 0);
    chk("rst_drop_addr", sadr[0], 0);
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    model_reset();
    #1;
    check_counts(0);
    do_read(0, 32'h2_0000, {$urandom, $urandom, $urandom, $urandom}, 2);

    for (int k = 0; k < 3; k++) begin
      sel = k;
      for (int n = 0; n < 150; n++) begin
        int op;
        op = $urandom_range(0, 19);
        if (op < 12)
          do_read(k, rand_addr(k), {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 3));
        else
          do_write(k, rand_addr(k), $urandom, $urandom_range(0, 3), op == 19);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
